// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Control FSM for a multicycle MIPS-style datapath. Drives the
//                datapath select/enable lines state by state, waits on
//                memory with a timeout, and counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_WAIT_EN = 1,
  parameter int TMO_W       = 4,
  parameter int TMO_MAX     = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             mem_ready,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic [3:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_HALT   = 4'd12,
    S_ERR    = 4'd13
  } state_t;

  localparam logic [3:0] C_ALU_ADD = 4'd0;
  localparam logic [3:0] C_ALU_SUB = 4'd1;
  localparam logic [3:0] C_ALU_AND = 4'd2;
  localparam logic [3:0] C_ALU_OR  = 4'd3;
  localparam logic [3:0] C_ALU_SLT = 4'd4;
  localparam logic [3:0] C_ALU_XOR = 4'd5;
  localparam logic [3:0] C_ALU_NOR = 4'd6;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_BNE   = 6'b000101;
  localparam logic [5:0] C_OP_BGTZ  = 6'b000111;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;
  localparam logic [5:0] C_OP_HALT  = 6'b111111;

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_opcode;
  logic [5:0]       r_funct;
  logic [TMO_W-1:0] r_wait;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_is_wait;
  logic             w_done;
  logic             w_tmo;
  logic [3:0]       w_exec_op;
  logic             w_funct_ok;
  logic             w_br_take;

  // Memory-access completion and timeout detection for the three wait states
  assign w_is_wait = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_done    = (MEM_WAIT_EN == 0) || mem_ready;
  assign w_tmo     = w_is_wait && !w_done && (r_wait == TMO_W'(TMO_MAX - 1));

  // R-type function decode from the funct captured at DECODE
  always_comb begin
    w_exec_op  = C_ALU_ADD;
    w_funct_ok = 1'b1;
    case (r_funct)
      6'b100000: w_exec_op = C_ALU_ADD;
      6'b100010: w_exec_op = C_ALU_SUB;
      6'b100100: w_exec_op = C_ALU_AND;
      6'b100101: w_exec_op = C_ALU_OR;
      6'b101010: w_exec_op = C_ALU_SLT;
      6'b100110: w_exec_op = C_ALU_XOR;
      6'b100111: w_exec_op = C_ALU_NOR;
      default:   w_funct_ok = 1'b0;
    endcase
  end

  // Branch condition resolved from the captured opcode and live ALU flags
  always_comb begin
    w_br_take = 1'b0;
    case (r_opcode)
      C_OP_BEQ:  w_br_take = alu_zero;
      C_OP_BNE:  w_br_take = !alu_zero;
      C_OP_BGTZ: w_br_take = !alu_zero && !alu_neg;
      default:   w_br_take = 1'b0;
    endcase
  end

  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_done)     w_next = S_DECODE;
        else if (w_tmo) w_next = S_ERR;
      end
      S_DECODE: begin
        case (opcode)
          C_OP_RTYPE:                     w_next = S_EXEC;
          C_OP_LW, C_OP_SW:               w_next = S_MEMADR;
          C_OP_BEQ, C_OP_BNE, C_OP_BGTZ:  w_next = S_BRANCH;
          C_OP_ADDI:                      w_next = S_ADDIEX;
          C_OP_J:                         w_next = S_JUMP;
          C_OP_HALT:                      w_next = S_HALT;
          default:                        w_next = S_ERR;
        endcase
      end
      S_MEMADR: w_next = (r_opcode == C_OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (w_done)     w_next = S_MEMWB;
        else if (w_tmo) w_next = S_ERR;
      end
      S_MEMWR: begin
        if (w_done)     w_next = S_FETCH;
        else if (w_tmo) w_next = S_ERR;
      end
      S_EXEC:   w_next = w_funct_ok ? S_ALUWB : S_ERR;
      S_ADDIEX: w_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      S_ERR:    w_next = S_ERR;
      default:  w_next = S_ERR;
    endcase
  end

  // State, instruction capture, wait counter, error flag and retire counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_FETCH;
      r_opcode <= '0;
      r_funct  <= '0;
      r_wait   <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_opcode <= opcode;
        r_funct  <= funct;
      end
      // Count only while stalled in the same wait state; any exit clears it
      if (w_is_wait && !w_done && (w_next == r_state))
        r_wait <= r_wait + TMO_W'(1);
      else
        r_wait <= '0;
      if (w_next == S_ERR)
        r_err <= 1'b1;
      // An instruction retires when control returns to FETCH from elsewhere
      if ((w_next == S_FETCH) && (r_state != S_FETCH))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Per-state control outputs; ir_write/pc_en also depend on inputs
  always_comb begin
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = C_ALU_ADD;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = w_done;
        pc_en     = w_done;
      end
      S_DECODE:  alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = w_exec_op;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB:  reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = C_ALU_SUB;
        pc_src    = 2'b01;
        pc_en     = w_br_take;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    // Write-side strobes are held off while reset is asserted
    if (!reset) begin
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign state     = r_state;
  assign err       = r_err;
  assign instr_cnt = r_cnt;

endmodule
`default_nettype wire
